// File: rtl/sample_sink_pkg.sv
// Shared definitions for the sample sink: state encoding,
// parameter defaults and the accumulator width helper.
package sample_sink_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_DELAY   = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam int LOG2_WIN_D = 3;
  localparam int CAP_DLY_D  = 4;
  localparam int TMO_D      = 15;

  // Sum of 2**log2_win bytes never overflows this width.
  function automatic int acc_w(input int log2_win);
    return 8 + log2_win;
  endfunction

endpackage

// File: rtl/sample_sink_if.sv
// Stop/ok grant handshake plus data byte from the fetch stage.
// master = upstream fetch stage, slave = sample sink.
interface sample_sink_if;
  logic       stop;
  logic [7:0] in;
  logic       ok;

  modport master (output stop, output in, input ok);
  modport slave  (input stop, input in, output ok);
endinterface

// File: rtl/sample_sink_window_acc.sv
// Window accumulator: sum, running max and index; publishes
// avg/max/nwin (and XOR check with SAMPLE_SINK_XOR_CHK_EN) on close.
module window_acc
  import sample_sink_pkg::*;
#(
  parameter int LOG2_WIN = LOG2_WIN_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add,
  input  logic        clr,
  input  logic [7:0]  in,
  output logic        done,
  output logic [7:0]  avg,
  output logic [7:0]  max,
  output logic [15:0] nwin
`ifdef SAMPLE_SINK_XOR_CHK_EN
  ,
  output logic [7:0]  chk
`endif
);

  localparam int AW = acc_w(LOG2_WIN);

  logic [AW-1:0]       sum;
  logic [AW-1:0]       sum_nx;
  logic [7:0]          wmax;
  logic [7:0]          max_nx;
  logic [LOG2_WIN-1:0] idx;
  logic                last;
`ifdef SAMPLE_SINK_XOR_CHK_EN
  logic [7:0]          xacc;
`endif

  assign sum_nx = sum + AW'(in);
  assign max_nx = (in > wmax) ? in : wmax;
  assign last   = (idx == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      wmax <= '0;
      idx  <= '0;
      done <= 1'b0;
      avg  <= '0;
      max  <= '0;
      nwin <= '0;
`ifdef SAMPLE_SINK_XOR_CHK_EN
      xacc <= '0;
      chk  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (clr) begin
        sum  <= '0;
        wmax <= '0;
        idx  <= '0;
`ifdef SAMPLE_SINK_XOR_CHK_EN
        xacc <= '0;
`endif
      end else if (add) begin
        if (last) begin
          avg  <= sum_nx[AW-1:LOG2_WIN];
          max  <= max_nx;
          done <= 1'b1;
          nwin <= nwin + 16'd1;
          sum  <= '0;
          wmax <= '0;
          idx  <= '0;
`ifdef SAMPLE_SINK_XOR_CHK_EN
          chk  <= xacc ^ in;
          xacc <= '0;
`endif
        end else begin
          sum  <= sum_nx;
          wmax <= max_nx;
          idx  <= idx + 1'b1;
`ifdef SAMPLE_SINK_XOR_CHK_EN
          xacc <= xacc ^ in;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/sample_sink.sv
// Sample sink: grants one fetch per stop request, captures a byte
// CAP_DLY clocks after stop falls and publishes window avg/max.
// Ports: clock, reset_, up (slave), avg, max, valid, nwin, err;
// SAMPLE_SINK_XOR_CHK_EN adds chk out and chk_ref in.
module sample_sink
  import sample_sink_pkg::*;
#(
  parameter int LOG2_WIN = LOG2_WIN_D,
  parameter int CAP_DLY  = CAP_DLY_D,
  parameter int TMO      = TMO_D
) (
  input  logic        clock,
  input  logic        reset_,
  sample_sink_if.slave up,
  output logic [7:0]  avg,
  output logic [7:0]  max,
  output logic        valid,
  output logic [15:0] nwin,
  output logic        err
`ifdef SAMPLE_SINK_XOR_CHK_EN
  ,
  output logic [7:0]  chk,
  input  logic [7:0]  chk_ref
`endif
);

  localparam int TMAX = (TMO > CAP_DLY) ? TMO : CAP_DLY;
  localparam int TW   = $clog2(TMAX + 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          ok;
  logic          tmo_hit;

  assign up.ok   = ok;
  assign tmo_hit = (state == S_GRANT) && up.stop
                && (timer == TW'(TMO - 1));

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= S_IDLE;
      timer <= '0;
      ok    <= 1'b0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          timer <= '0;
          if (up.stop && !err) begin
            state <= S_GRANT;
            ok    <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!up.stop) begin
            state <= S_DELAY;
            timer <= '0;
          end else if (tmo_hit) begin
            state <= S_IDLE;
            timer <= '0;
            ok    <= 1'b0;
            err   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DELAY: begin
          // CAP_DLY-1 cycles here, then one CAPTURE cycle.
          if (timer == TW'(CAP_DLY - 2)) begin
            state <= S_CAPTURE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_CAPTURE: begin
          state <= S_IDLE;
          ok    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
`ifdef SAMPLE_SINK_XOR_CHK_EN
      if (valid && (chk != chk_ref))
        err <= 1'b1;
`endif
    end
  end

  window_acc #(.LOG2_WIN(LOG2_WIN)) u_acc (
    .clk   (clock),
    .rst_n (reset_),
    .add   (state == S_CAPTURE),
    .clr   (tmo_hit),
    .in    (up.in),
    .done  (valid),
    .avg   (avg),
    .max   (max),
    .nwin  (nwin)
`ifdef SAMPLE_SINK_XOR_CHK_EN
    ,
    .chk   (chk)
`endif
  );

endmodule

// File: tb/tb_sample_sink.sv
// Scoreboard bench for sample_sink: windows push expected
// avg/max/nwin, a monitor pops and compares on each valid pulse.
module tb_sample_sink;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic [7:0]  avg;
  logic [7:0]  max;
  logic        valid;
  logic [15:0] nwin;
  logic        err;
`ifdef SAMPLE_SINK_XOR_CHK_EN
  logic [7:0]  chk;
  logic [7:0]  chk_ref = 8'h00;
`endif

  always #5 clock = ~clock;

  sample_sink_if bus();

  sample_sink dut (
    .clock   (clock),
    .reset_  (reset_),
    .up      (bus),
    .avg     (avg),
    .max     (max),
    .valid   (valid),
    .nwin    (nwin),
    .err     (err)
`ifdef SAMPLE_SINK_XOR_CHK_EN
    ,
    .chk     (chk),
    .chk_ref (chk_ref)
`endif
  );

  typedef struct {
    logic [7:0]  avg;
    logic [7:0]  max;
    logic [7:0]  chk;
    logic [15:0] nwin;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          exp_pulses = 0;
  logic [15:0] exp_nwin = '0;
  logic        prev_v = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare published window against scoreboard head.
  always @(negedge clock) begin
    if (valid) begin
      exp_t e;
      pulses++;
      check("valid_width", {31'd0, prev_v}, 32'd0);
      if (q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("avg", {24'd0, avg}, {24'd0, e.avg});
        check("max", {24'd0, max}, {24'd0, e.max});
        check("nwin", {16'd0, nwin}, {16'd0, e.nwin});
`ifdef SAMPLE_SINK_XOR_CHK_EN
        check("chk", {24'd0, chk}, {24'd0, e.chk});
`endif
      end
    end
    prev_v = valid;
  end

  task automatic wait_ok(input logic v, input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.ok === v) return;
    end
    check(name, 32'd1, 32'd0);
  endtask

  // Upstream model: request, wait for grant, drop stop, hold byte.
  task automatic fetch(input logic [7:0] b);
    bus.in   = b;
    bus.stop = 1'b1;
    wait_ok(1'b1, "grant_timeout");
    bus.stop = 1'b0;
    wait_ok(1'b0, "release_timeout");
  endtask

  task automatic window(input logic [7:0] b [8],
                        input logic [7:0] ea,
                        input logic [7:0] em,
                        input logic [7:0] ec);
    exp_t e;
    exp_nwin++;
    e.avg  = ea;
    e.max  = em;
    e.chk  = ec;
    e.nwin = exp_nwin;
    q.push_back(e);
    exp_pulses++;
    for (int i = 0; i < 8; i++) fetch(b[i]);
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    exp_nwin = '0;
  endtask

  initial begin
    int cnt;
    bus.stop = 1'b0;
    bus.in   = 8'h00;

    // Reset, then stay idle
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_ok", {31'd0, bus.ok}, 32'd0);
    check("rst_avg", {24'd0, avg}, 32'd0);
    check("rst_max", {24'd0, max}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_nwin", {16'd0, nwin}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset_ = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clock);
      if (bus.ok || valid || nwin != 0 || err) cnt++;
    end
    check("idle_quiet", cnt, 32'd0);

    // Single grant with 0x5A
    bus.in   = 8'h5A;
    bus.stop = 1'b1;
    @(negedge clock);
    check("grant_next", {31'd0, bus.ok}, 32'd1);
    bus.stop = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.ok) cnt++;
      else break;
    end
    check("grant_hold", cnt, 32'd4);
    check("single_nwin", {16'd0, nwin}, 32'd0);
    do_reset();

    // Full windows
`ifdef SAMPLE_SINK_XOR_CHK_EN
    chk_ref = 8'h9F;
`endif
    window('{8'd10, 8'd20, 8'd30, 8'd40,
             8'd50, 8'd60, 8'd70, 8'd255},
           8'd66, 8'd255, 8'h9F);
`ifdef SAMPLE_SINK_XOR_CHK_EN
    chk_ref = 8'h08;
`endif
    window('{8'd1, 8'd2, 8'd3, 8'd4,
             8'd5, 8'd6, 8'd7, 8'd8},
           8'd4, 8'd8, 8'h08);
    repeat (3) @(negedge clock);
    check("win_err", {31'd0, err}, 32'd0);
    check("win_nwin", {16'd0, nwin}, 32'd2);

    // Timeout: stop held high after grant
    bus.stop = 1'b1;
    @(negedge clock);
    check("tmo_grant", {31'd0, bus.ok}, 32'd1);
    repeat (14) @(negedge clock);
    check("tmo_early_err", {31'd0, err}, 32'd0);
    check("tmo_early_ok", {31'd0, bus.ok}, 32'd1);
    @(negedge clock);
    check("tmo_err", {31'd0, err}, 32'd1);
    check("tmo_ok", {31'd0, bus.ok}, 32'd0);
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.ok) cnt++;
    end
    check("tmo_locked", cnt, 32'd0);
    check("tmo_sticky", {31'd0, err}, 32'd1);
    bus.stop = 1'b0;

    // Reset mid-window, in DELAY
    do_reset();
    check("rst2_err", {31'd0, err}, 32'd0);
    check("rst2_nwin", {16'd0, nwin}, 32'd0);
    for (int i = 0; i < 5; i++) fetch(8'h77);
    bus.in   = 8'h77;
    bus.stop = 1'b1;
    wait_ok(1'b1, "grant_timeout");
    bus.stop = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset_ = 1'b0;
    #1 check("async_ok", {31'd0, bus.ok}, 32'd0);
    @(negedge clock);
    reset_ = 1'b1;
    exp_nwin = '0;
`ifdef SAMPLE_SINK_XOR_CHK_EN
    chk_ref = 8'h00;
`endif
    window('{8'h10, 8'h10, 8'h10, 8'h10,
             8'h10, 8'h10, 8'h10, 8'h10},
           8'h10, 8'h10, 8'h00);
    repeat (3) @(negedge clock);
    check("clean_err", {31'd0, err}, 32'd0);

`ifdef SAMPLE_SINK_XOR_CHK_EN
    // Check mismatch sets err
    chk_ref = 8'h00;
    window('{8'd1, 8'd2, 8'd3, 8'd4,
             8'd5, 8'd6, 8'd7, 8'd8},
           8'd4, 8'd8, 8'h08);
    repeat (3) @(negedge clock);
    check("chk_err", {31'd0, err}, 32'd1);
`endif

    repeat (5) @(negedge clock);
    check("sb_empty", q.size(), 32'd0);
    check("pulse_count", pulses, exp_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
